// File: rtl/configure.sv
// Build-time defaults and shared types for the memory responder.
package configure;

   localparam int default_ram_depth   = 4096;
   localparam int default_wait_states = 0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } resp_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

endpackage

// File: rtl/wires.sv
// CPU <-> memory bus bundles shared across the core.
package wires;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

endpackage

// File: rtl/responder_ram.sv
// Byte-writable single-port word RAM with registered read data.
module responder_ram #(
   parameter int depth = 4096
) (
   input  logic                     clock,
   input  logic                     en,
   input  logic [3:0]               we,
   input  logic [$clog2(depth)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [depth];

   always_ff @(posedge clock) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         if (we == 4'b0000) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Dual-port (imem/dmem) responder over one shared RAM, data port first.
module mem_responder
   import wires::*;
   import configure::*;
#(
   parameter int ram_depth   = default_ram_depth,
   parameter int wait_states = default_wait_states
) (
   input  logic        clock,
   input  logic        reset,
   input  mem_in_type  imemory_in,
   output mem_out_type imemory_out,
   input  mem_in_type  dmemory_in,
   output mem_out_type dmemory_out
);

   localparam int         aw = $clog2(ram_depth);
   localparam logic [3:0] ws = 4'(wait_states);

   resp_state_t state;
   logic [3:0]  cnt;

   req_t pend_i, pend_d, svc;
   req_t new_i, new_d, sel, op;
   logic pend_i_v, pend_d_v, svc_d;
   logic busy_i, busy_d, take_i, take_d;
   logic eff_i_v, eff_d_v, can_sel;
   logic sel_i, sel_d, op_go, op_d;
   logic rdy_i, rdy_d, rd_flag;
   logic [31:0] ram_q;
   logic        unused_bits;

   always_comb begin
      busy_i  = pend_i_v || (state == WAIT && !svc_d);
      busy_d  = pend_d_v || (state == WAIT && svc_d);
      take_i  = imemory_in.mem_valid && !busy_i;
      take_d  = dmemory_in.mem_valid && !busy_d;

      new_i.addr  = imemory_in.mem_addr;
      new_i.wdata = imemory_in.mem_wdata;
      new_i.wstrb = imemory_in.mem_wstrb;
      if (pend_i_v) new_i = pend_i;
      new_d.addr  = dmemory_in.mem_addr;
      new_d.wdata = dmemory_in.mem_wdata;
      new_d.wstrb = dmemory_in.mem_wstrb;
      if (pend_d_v) new_d = pend_d;

      eff_i_v = pend_i_v || take_i;
      eff_d_v = pend_d_v || take_d;
      can_sel = (state != WAIT);
      sel_d   = can_sel && eff_d_v;
      sel_i   = can_sel && eff_i_v && !eff_d_v;
      sel     = sel_d ? new_d : new_i;

      // Zero wait states commit straight from the selection edge.
      op_go = 1'b0;
      op    = sel;
      op_d  = sel_d;
      if (state == WAIT) begin
         op_go = (cnt == ws);
         op    = svc;
         op_d  = svc_d;
      end else if (ws == 4'd0) begin
         op_go = sel_d || sel_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         pend_i_v <= 1'b0;
         pend_d_v <= 1'b0;
         pend_i   <= '0;
         pend_d   <= '0;
         svc      <= '0;
         svc_d    <= 1'b0;
         rdy_i    <= 1'b0;
         rdy_d    <= 1'b0;
         rd_flag  <= 1'b0;
      end else begin
         rdy_d   <= op_go && op_d;
         rdy_i   <= op_go && !op_d;
         rd_flag <= op_go && (op.wstrb == 4'b0000);

         if (sel_d) begin
            pend_d_v <= 1'b0;
         end else if (take_d) begin
            pend_d_v <= 1'b1;
            pend_d   <= new_d;
         end

         if (sel_i) begin
            pend_i_v <= 1'b0;
         end else if (take_i) begin
            pend_i_v <= 1'b1;
            pend_i   <= new_i;
         end

         unique case (state)
            IDLE, RESP: begin
               if (sel_d || sel_i) begin
                  svc   <= sel;
                  svc_d <= sel_d;
                  if (ws == 4'd0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'd1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt == ws) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset gates the enable so an aborted write never lands.
   responder_ram #(
      .depth(ram_depth)
   ) u_ram (
      .clock(clock),
      .en   (op_go && !reset),
      .we   (op.wstrb),
      .addr (op.addr[aw+1:2]),
      .wdata(op.wdata),
      .rdata(ram_q)
   );

   always_comb begin
      imemory_out           = '0;
      dmemory_out           = '0;
      imemory_out.mem_ready = rdy_i;
      dmemory_out.mem_ready = rdy_d;
      if (rdy_i && rd_flag) imemory_out.mem_rdata = ram_q;
      if (rdy_d && rd_flag) dmemory_out.mem_rdata = ram_q;
   end

   assign unused_bits = ^{imemory_in.mem_instr, dmemory_in.mem_instr,
                          op.addr[31:aw+2], op.addr[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: zero-wait and three-wait responders side by side.
module tb_mem_responder;
   import wires::*;

   logic        clock;
   logic        rst0, rst3;
   mem_in_type  i0, d0, i3, d3;
   mem_out_type oi0, od0, oi3, od3;
   int          checks = 0;
   int          errors = 0;

   mem_responder #(.ram_depth(4096), .wait_states(0)) dut0 (
      .clock(clock), .reset(rst0),
      .imemory_in(i0), .imemory_out(oi0),
      .dmemory_in(d0), .dmemory_out(od0)
   );

   mem_responder #(.ram_depth(4096), .wait_states(3)) dut3 (
      .clock(clock), .reset(rst3),
      .imemory_in(i3), .imemory_out(oi3),
      .dmemory_in(d3), .dmemory_out(od3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic mem_in_type mk(input logic [31:0] a,
                                     input logic [31:0] wd,
                                     input logic [3:0]  s);
      mem_in_type r;
      r           = '0;
      r.mem_valid = 1'b1;
      r.mem_addr  = a;
      r.mem_wdata = wd;
      r.mem_wstrb = s;
      return r;
   endfunction

   task automatic drive(input bit w3, input bit dp, input mem_in_type r);
      if (!w3 && dp) d0 = r;
      else if (!w3)  i0 = r;
      else if (dp)   d3 = r;
      else           i3 = r;
   endtask

   function automatic mem_out_type port_out(input bit w3, input bit dp);
      if (!w3) return dp ? od0 : oi0;
      return dp ? od3 : oi3;
   endfunction

   task automatic access(input bit w3, input bit dp,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output logic [31:0] rd);
      mem_out_type o;
      bit got;
      drive(w3, dp, mk(a, wd, s));
      step();
      drive(w3, dp, '0);
      rd  = '0;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         o = port_out(w3, dp);
         if (o.mem_ready === 1'b1) begin
            rd  = o.mem_rdata;
            got = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL access_timeout addr=%h: no ready, required ready within 40 cycles", a);
      end
   endtask

   task automatic test_reset();
      i0 = '0; d0 = '0; i3 = '0; d3 = '0;
      rst0 = 1'b1;
      rst3 = 1'b1;
      step();
      step();
      checks++;
      if (oi0 !== '0) begin
         errors++;
         $display("FAIL reset_i0: got %h, required 0", oi0);
      end
      checks++;
      if (od0 !== '0) begin
         errors++;
         $display("FAIL reset_d0: got %h, required 0", od0);
      end
      checks++;
      if (oi3 !== '0) begin
         errors++;
         $display("FAIL reset_i3: got %h, required 0", oi3);
      end
      checks++;
      if (od3 !== '0) begin
         errors++;
         $display("FAIL reset_d3: got %h, required 0", od3);
      end
      rst0 = 1'b0;
      rst3 = 1'b0;
      step();
   endtask

   task automatic test_read();
      logic [31:0] rd;
      access(1'b0, 1'b1, 32'h40, 32'h10, 4'hF, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL write_rdata: got %h, required 0", rd);
      end
      step();
      drive(1'b0, 1'b1, mk(32'h40, 32'h0, 4'h0));
      step();
      drive(1'b0, 1'b1, '0);
      checks++;
      if (od0.mem_ready !== 1'b1 || od0.mem_rdata !== 32'h10) begin
         errors++;
         $display("FAIL read_t1: got ready=%b rdata=%h, required 1/00000010",
                  od0.mem_ready, od0.mem_rdata);
      end
      checks++;
      if (oi0.mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL read_other_port: got ready=%b, required 0", oi0.mem_ready);
      end
      step();
      checks++;
      if (od0.mem_ready !== 1'b0 || od0.mem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL read_t2: got ready=%b rdata=%h, required 0/0",
                  od0.mem_ready, od0.mem_rdata);
      end
      drive(1'b0, 1'b0, mk(32'h40, 32'h0, 4'h0));
      step();
      drive(1'b0, 1'b0, '0);
      checks++;
      if (oi0.mem_ready !== 1'b1 || oi0.mem_rdata !== 32'h10) begin
         errors++;
         $display("FAIL iread_t1: got ready=%b rdata=%h, required 1/00000010",
                  oi0.mem_ready, oi0.mem_rdata);
      end
      step();
   endtask

   task automatic test_byte_write();
      logic [31:0] rd;
      access(1'b0, 1'b1, 32'h80, 32'hAABBCCDD, 4'hF, rd);
      access(1'b0, 1'b1, 32'h80, 32'h00001100, 4'h2, rd);
      access(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, rd);
      checks++;
      if (rd !== 32'hAABB11DD) begin
         errors++;
         $display("FAIL byte_write: got %h, required aabb11dd", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      access(1'b0, 1'b0, 32'h0, 32'h11111111, 4'hF, rd);
      access(1'b0, 1'b1, 32'h4, 32'h22222222, 4'hF, rd);
      step();
      drive(1'b0, 1'b0, mk(32'h0, 32'h0, 4'h0));
      drive(1'b0, 1'b1, mk(32'h4, 32'h0, 4'h0));
      step();
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b1, '0);
      checks++;
      if (od0.mem_ready !== 1'b1 || od0.mem_rdata !== 32'h22222222
          || oi0.mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL collide_t1: got d=%b/%h i=%b, required d=1/22222222 i=0",
                  od0.mem_ready, od0.mem_rdata, oi0.mem_ready);
      end
      step();
      checks++;
      if (oi0.mem_ready !== 1'b1 || oi0.mem_rdata !== 32'h11111111
          || od0.mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL collide_t2: got i=%b/%h d=%b, required i=1/11111111 d=0",
                  oi0.mem_ready, oi0.mem_rdata, od0.mem_ready);
      end
      step();
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      access(1'b1, 1'b1, 32'h0, 32'h77, 4'hF, rd);
      drive(1'b1, 1'b0, mk(32'h0, 32'h0, 4'h0));
      step();
      drive(1'b1, 1'b0, '0);
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if (oi3.mem_ready !== 1'b0 || od3.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_early t+%0d: got i=%b d=%b, required 0/0",
                     k, oi3.mem_ready, od3.mem_ready);
         end
         step();
      end
      checks++;
      if (oi3.mem_ready !== 1'b1 || oi3.mem_rdata !== 32'h77) begin
         errors++;
         $display("FAIL wait_t4: got ready=%b rdata=%h, required 1/00000077",
                  oi3.mem_ready, oi3.mem_rdata);
      end
      step();
      checks++;
      if (oi3.mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL wait_t5: got ready=%b, required 0", oi3.mem_ready);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      access(1'b0, 1'b1, 32'h4000_0008, 32'h55, 4'hF, rd);
      access(1'b0, 1'b1, 32'h0000_000A, 32'h0, 4'h0, rd);
      checks++;
      if (rd !== 32'h55) begin
         errors++;
         $display("FAIL wrap: got %h, required 00000055", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      access(1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF, rd);
      drive(1'b1, 1'b1, mk(32'h100, 32'hDEADBEEF, 4'hF));
      step();
      drive(1'b1, 1'b1, '0);
      step();
      for (int c = 2; c <= 10; c++) begin
         rst3 = (c == 2);
         checks++;
         if (od3.mem_ready !== 1'b0 || oi3.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort t+%0d: got d=%b i=%b, required 0/0",
                     c, od3.mem_ready, oi3.mem_ready);
         end
         step();
      end
      rst3 = 1'b0;
      access(1'b1, 1'b1, 32'h100, 32'h0, 4'h0, rd);
      checks++;
      if (rd !== 32'h12345678) begin
         errors++;
         $display("FAIL abort_word: got %h, required 12345678", rd);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_byte_write();
      test_back_to_back();
      test_wait_states();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ram_depth, default 4096, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter wait_states, default 0, extra cycles per access (range 0..15).
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port imemory_in, input, mem_in_type, instruction-side request from cpu.
REQ-006 SHALL have port imemory_out, output, mem_out_type, instruction-side response to cpu.
REQ-007 SHALL have port dmemory_in, input, mem_in_type, data-side request from cpu.
REQ-008 SHALL have port dmemory_out, output, mem_out_type, data-side response to cpu.
REQ-009 SHALL use only mem_valid, mem_addr, mem_wdata, mem_wstrb of mem_in_type and ignore all other fields.

Function
REQ-010 SHALL treat mem_valid=1 in any cycle as a one-cycle request pulse; request fields are valid only in that cycle.
REQ-011 SHALL latch each port's request (addr, wdata, wstrb) into a per-port pending register in the cycle it arrives.
REQ-012 SHALL allow at most one outstanding request per port; a mem_valid on a port with a pending or in-service request is ignored.
REQ-013 SHALL run FSM states IDLE, WAIT, RESP: IDLE->WAIT if a request is selected and wait_states>0, IDLE->RESP if wait_states=0, WAIT->RESP when wait counter reaches wait_states, RESP->IDLE, or RESP->WAIT/RESP directly if another request is pending.
REQ-014 SHALL arbitrate with fixed priority: data port over instruction port when both are pending or arrive in the same cycle.
REQ-015 SHALL treat a request arriving in cycle t while idle as eligible for selection in cycle t (no idle bubble).
REQ-016 SHALL assert mem_ready for exactly one cycle per accepted request, at cycle t+1+wait_states after selection.
REQ-017 SHALL drive mem_rdata with the addressed word in the mem_ready cycle for reads (mem_wstrb=0), and 0 in all other cycles.
REQ-018 SHALL perform a write when mem_wstrb!=0, updating only bytes whose strobe bit is 1, and return mem_rdata=0 with mem_ready.
REQ-019 SHALL index RAM by mem_addr[log2(ram_depth)+1:2], ignoring addr[1:0] and wrapping higher address bits.
REQ-020 SHALL make a write visible to any request selected in the cycle after its mem_ready.
REQ-021 SHALL keep mem_ready=0 on the port not being served.
REQ-022 SHALL support back-to-back service: with both ports pending and wait_states=0, instruction ready follows data ready by one cycle.

Reset
REQ-023 SHALL, on reset=1, set FSM to IDLE, clear wait counter and both pending registers, and drive mem_ready=0, mem_rdata=0 on both outputs in the following cycle.
REQ-024 SHALL abort any in-flight request on reset without issuing mem_ready and without completing a not-yet-committed write.
REQ-025 SHALL not initialise RAM contents on reset.

Structure
REQ-026 SHALL take mem_in_type and mem_out_type from the wires package unchanged.
REQ-027 SHALL define ram_depth and wait_states defaults as constants in the configure package.
REQ-028 SHALL place the byte-writable single-port storage array in one sub-module named responder_ram.
REQ-029 SHALL fit in 120-400 lines of RTL.

Verification
REQ-030 Read, wait_states=0: preload word 0x10 at addr 0x40; dmem read 0x40 at t -> dmemory_out ready=1, rdata=0x10 at t+1 only.
REQ-031 Byte write: write 0xAABBCCDD wstrb=0xF to 0x80, then wstrb=0x2 wdata=0x00001100 -> read 0x80 returns 0xAABB11DD.
REQ-032 Collision, wait_states=0: imem read 0x0 and dmem read 0x4 same cycle t -> dmem ready at t+1, imem ready at t+2, rdata correct each.
REQ-033 Wait states=3: imem read at t -> imem ready at t+4, no ready at t+1..t+3.
REQ-034 Wrap/ignored bits: ram_depth=4096, write 0x55 to 0x4000_0008, read 0x0000_000A -> rdata=0x55.
REQ-035 Reset mid-access, wait_states=3: dmem write at t, reset at t+2 -> no mem_ready in t+2..t+10, target word unchanged.
